// File: rtl/spi_wb_burst_bridge_if.sv
// SPI command/status words plus the Wishbone master pins of the debug bridge.
// master = bridge side, slave = SPI shift chain / Wishbone mux side.
interface spi_wb_burst_bridge_if #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int LENW = 8
);
  localparam int SW = DW / 8;

  logic [AW+DW+SW+LENW+7:0] spi_out;
  logic [2*DW+LENW+7:0]     spi_in;
  logic [AW-1:0]            o_wb_adr;
  logic [DW-1:0]            o_wb_dat;
  logic [SW-1:0]            o_wb_sel;
  logic                     o_wb_we;
  logic                     o_wb_cyc;
  logic [DW-1:0]            i_wb_rdt;
  logic                     i_wb_ack;
  logic                     cpu_reset;
  logic                     system_reset;

  modport master (
    input  spi_out, i_wb_rdt, i_wb_ack,
    output spi_in, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
    output cpu_reset, system_reset
  );

  modport slave (
    output spi_out, i_wb_rdt, i_wb_ack,
    input  spi_in, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_cyc,
    input  cpu_reset, system_reset
  );
endinterface

// File: rtl/spi_wb_burst_bridge.sv
// SPI-debug command word to Wishbone master: single, fill-write and read-checksum bursts.
// Latency: cyc rises the cycle after an accepted start edge, one idle cycle between beats.
// Backpressure: none upstream; each beat waits for ack, bounded by TIMEOUT cycles.
module spi_wb_burst_bridge #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int LENW    = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  spi_reset,
  spi_wb_burst_bridge_if.master bus
);
  localparam int SW     = DW / 8;
  localparam int TW     = $clog2(TIMEOUT + 1);
  localparam int LEN_LO = 8;
  localparam int SEL_LO = LEN_LO + LENW;
  localparam int DAT_LO = SEL_LO + SW;
  localparam int ADR_LO = DAT_LO + DW;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_NEXT = 2'd2;

  logic            ctrl_cpu, ctrl_sys, ctrl_start, ctrl_we, ctrl_incr, ctrl_abort;
  logic [AW-1:0]   cmd_adr;
  logic [DW-1:0]   cmd_dat;
  logic [SW-1:0]   cmd_sel;
  logic [LENW-1:0] cmd_len;
  logic            start_pulse;

  assign ctrl_cpu   = bus.spi_out[0];
  assign ctrl_sys   = bus.spi_out[1];
  assign ctrl_start = bus.spi_out[2];
  assign ctrl_we    = bus.spi_out[3];
  assign ctrl_incr  = bus.spi_out[4];
  assign ctrl_abort = bus.spi_out[5];
  assign cmd_len    = bus.spi_out[LEN_LO +: LENW];
  assign cmd_sel    = bus.spi_out[SEL_LO +: SW];
  assign cmd_dat    = bus.spi_out[DAT_LO +: DW];
  assign cmd_adr    = bus.spi_out[ADR_LO +: AW];

  logic [1:0]      state_q, state_d;
  logic            start_q, start_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   dat_q, dat_d;
  logic [SW-1:0]   sel_q, sel_d;
  logic            we_q, we_d;
  logic            incr_q, incr_d;
  logic [LENW-1:0] len_q, len_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [LENW-1:0] beats_q, beats_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic [DW-1:0]   rsum_q, rsum_d;
  logic            timeout_q, timeout_d;
  logic            rejected_q, rejected_d;

  assign start_pulse = ctrl_start & ~start_q;

  always_comb begin
    state_d    = state_q;
    start_d    = ctrl_start;
    adr_d      = adr_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    we_d       = we_q;
    incr_d     = incr_q;
    len_d      = len_q;
    timer_d    = timer_q;
    beats_d    = beats_q;
    rdata_d    = rdata_q;
    rsum_d     = rsum_q;
    timeout_d  = timeout_q;
    rejected_d = rejected_q;

    // The CPU must be held in reset so the bridge owns the bus exclusively.
    if (start_pulse) begin
      if (state_q == ST_IDLE && ctrl_cpu) begin
        adr_d      = cmd_adr;
        dat_d      = cmd_dat;
        sel_d      = cmd_sel;
        we_d       = ctrl_we;
        incr_d     = ctrl_incr;
        len_d      = cmd_len;
        timer_d    = '0;
        beats_d    = '0;
        rsum_d     = '0;
        timeout_d  = 1'b0;
        rejected_d = 1'b0;
        state_d    = ST_BUS;
      end else begin
        rejected_d = 1'b1;
      end
    end

    case (state_q)
      ST_BUS: begin
        if (bus.i_wb_ack) begin
          beats_d = beats_q + LENW'(1);
          if (!we_q) begin
            rdata_d = bus.i_wb_rdt;
            rsum_d  = rsum_q + bus.i_wb_rdt;
          end
          state_d = (beats_q == len_q) ? ST_IDLE : ST_NEXT;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + TW'(1);
        end
        // A beat acked in the same cycle as abort is still counted above.
        if (ctrl_abort) state_d = ST_IDLE;
      end
      ST_NEXT: begin
        if (incr_q) adr_d = adr_q + AW'(SW);
        timer_d = '0;
        state_d = ctrl_abort ? ST_IDLE : ST_BUS;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge spi_reset) begin
    if (!spi_reset) begin
      state_q    <= ST_IDLE;
      start_q    <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      incr_q     <= 1'b0;
      len_q      <= '0;
      timer_q    <= '0;
      beats_q    <= '0;
      rdata_q    <= '0;
      rsum_q     <= '0;
      timeout_q  <= 1'b0;
      rejected_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      incr_q     <= incr_d;
      len_q      <= len_d;
      timer_q    <= timer_d;
      beats_q    <= beats_d;
      rdata_q    <= rdata_d;
      rsum_q     <= rsum_d;
      timeout_q  <= timeout_d;
      rejected_q <= rejected_d;
    end
  end

  assign bus.o_wb_cyc     = (state_q == ST_BUS);
  assign bus.o_wb_adr     = adr_q;
  assign bus.o_wb_dat     = dat_q;
  assign bus.o_wb_sel     = sel_q;
  assign bus.o_wb_we      = we_q;
  assign bus.cpu_reset    = ctrl_cpu;
  assign bus.system_reset = ctrl_sys;
  assign bus.spi_in       = {rdata_q, rsum_q, beats_q, 2'b00, rejected_q, timeout_q,
                             (state_q != ST_IDLE), 1'b0, ctrl_sys, ctrl_cpu};
endmodule

// File: tb/tb_spi_wb_burst_bridge.sv
// Bench for spi_wb_burst_bridge: directed scenarios with literal expectations, then random
// commands/acks/resets, all compared every cycle against a transaction-level burst model.
module tb_spi_wb_burst_bridge;
  localparam int AW = 32, DW = 32, LENW = 8, TIMEOUT = 8, SW = 4;

  logic clk = 1'b0;
  logic spi_reset = 1'b1;

  spi_wb_burst_bridge_if #(.AW(AW), .DW(DW), .LENW(LENW)) bus();

  spi_wb_burst_bridge #(.AW(AW), .DW(DW), .LENW(LENW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .spi_reset(spi_reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Burst model: progress is beat count, hop count and cycles waited, not a state code.
  bit          m_active, m_gap, m_we, m_incr, m_to, m_rej, m_prev;
  int          m_wait, m_beats, m_len, m_hops;
  logic [31:0] m_base, m_dat, m_rdata, m_rsum;
  logic [3:0]  m_sel;

  task automatic model_reset();
    m_active = 0; m_gap = 0; m_we = 0; m_incr = 0; m_to = 0; m_rej = 0; m_prev = 0;
    m_wait = 0; m_beats = 0; m_len = 0; m_hops = 0;
    m_base = '0; m_dat = '0; m_rdata = '0; m_rsum = '0; m_sel = '0;
  endtask

  task automatic model_step();
    logic [7:0] c;
    bit pulse, was_busy;
    c = bus.spi_out[7:0];
    pulse = c[2] && !m_prev;
    m_prev = c[2];
    was_busy = m_active;
    if (m_active && !m_gap) begin
      if (bus.i_wb_ack) begin
        if (!m_we) begin
          m_rdata = bus.i_wb_rdt;
          m_rsum  = m_rsum + bus.i_wb_rdt;
        end
        if (m_beats == m_len || c[5]) m_active = 0;
        else m_gap = 1;
        m_beats++;
      end else if (m_wait == TIMEOUT - 1) begin
        m_active = 0;
        m_to = 1;
      end else begin
        m_wait++;
        if (c[5]) m_active = 0;
      end
    end else if (m_active) begin
      m_hops++;
      m_gap = 0;
      m_wait = 0;
      if (c[5]) m_active = 0;
    end
    if (pulse) begin
      if (!was_busy && c[0]) begin
        m_base = bus.spi_out[83:52]; m_dat = bus.spi_out[51:20];
        m_sel = bus.spi_out[19:16]; m_len = int'(bus.spi_out[15:8]);
        m_we = c[3]; m_incr = c[4];
        m_hops = 0; m_wait = 0; m_beats = 0; m_rsum = '0;
        m_to = 0; m_rej = 0; m_active = 1; m_gap = 0;
      end else begin
        m_rej = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!spi_reset) model_reset();
    check("cyc", bus.o_wb_cyc, m_active && !m_gap);
    check("adr", bus.o_wb_adr, m_incr ? m_base + 32'(m_hops * SW) : m_base);
    check("dat", bus.o_wb_dat, m_dat);
    check("sel", bus.o_wb_sel, m_sel);
    check("we", bus.o_wb_we, m_we);
    check("spi_in", bus.spi_in, {m_rdata, m_rsum, 8'(m_beats), 2'b00, m_rej, m_to,
                                 m_active, 1'b0, bus.spi_out[1:0]});
    check("cpu_reset", bus.cpu_reset, bus.spi_out[0]);
    check("system_reset", bus.system_reset, bus.spi_out[1]);
    if (spi_reset) model_step();
  end

  // Wishbone slave: directed mode acks on the ack_at-th cycle of each beat, random mode is free-running.
  bit          rand_ack = 0;
  int          ack_pct = 30;
  int          ack_at = 0;
  logic [31:0] rd_q[$];

  initial begin
    int wcnt = 0;
    bus.i_wb_ack = 1'b0;
    bus.i_wb_rdt = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rand_ack) begin
        bus.i_wb_ack = ($urandom_range(99) < ack_pct);
        bus.i_wb_rdt = $urandom;
      end else if (bus.o_wb_cyc) begin
        wcnt++;
        if (ack_at != 0 && wcnt == ack_at) begin
          bus.i_wb_ack = 1'b1;
          bus.i_wb_rdt = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h0;
        end else begin
          bus.i_wb_ack = 1'b0;
        end
      end else begin
        wcnt = 0;
        bus.i_wb_ack = 1'b0;
      end
    end
  end

  logic [31:0] adr_log[$];
  logic [31:0] dat_log[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [7:0] l,
                       input bit we, input bit inc);
    bus.spi_out = {a, d, 4'hF, l, 3'b000, inc, we, 3'b101};
    tick();
    bus.spi_out[2] = 1'b0;
  endtask

  task automatic wait_idle(output int ncyc, output int nbusy);
    ncyc = 0;
    nbusy = 0;
    adr_log.delete();
    dat_log.delete();
    for (int i = 0; i < 100; i++) begin
      if (!bus.spi_in[3]) return;
      nbusy++;
      if (bus.o_wb_cyc) begin
        ncyc++;
        adr_log.push_back(bus.o_wb_adr);
        dat_log.push_back(bus.o_wb_dat);
      end
      tick();
    end
    check("wait_idle_busy", bus.spi_in[3], 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nc, nb;
    logic [7:0] c;
    bus.spi_out = '0;
    #2 spi_reset = 1'b0;
    repeat (3) tick();
    check("rst_cyc", bus.o_wb_cyc, 0);
    check("rst_spi_in", bus.spi_in, 0);
    check("rst_adr", bus.o_wb_adr, 0);
    spi_reset = 1'b1;
    bus.spi_out[0] = 1'b1;
    tick();

    // Single read, acked on the 4th bus cycle.
    ack_at = 4;
    rd_q.push_back(32'hDEADBEEF);
    issue(32'h100, 32'h0, 8'd0, 1'b0, 1'b0);
    wait_idle(nc, nb);
    check("t1_cyc_cycles", nc, 4);
    check("t1_rdata", bus.spi_in[79:48], 32'hDEADBEEF);
    check("t1_rsum", bus.spi_in[47:16], 32'hDEADBEEF);
    check("t1_beats", bus.spi_in[15:8], 1);

    // Fill write burst with incrementing address.
    ack_at = 1;
    issue(32'h200, 32'hA5A5A5A5, 8'd3, 1'b1, 1'b1);
    wait_idle(nc, nb);
    check("t2_cyc_cycles", nc, 4);
    check("t2_busy_cycles", nb, 7);
    for (int i = 0; i < adr_log.size(); i++) begin
      check("t2_adr", adr_log[i], 32'h200 + 32'(4 * i));
      check("t2_dat", dat_log[i], 32'hA5A5A5A5);
    end
    check("t2_beats", bus.spi_in[15:8], 4);

    // Read checksum at a fixed address.
    ack_at = 2;
    rd_q.push_back(32'hFFFFFFFF);
    rd_q.push_back(32'h00000002);
    issue(32'h300, 32'h0, 8'd1, 1'b0, 1'b0);
    wait_idle(nc, nb);
    for (int i = 0; i < adr_log.size(); i++) check("t3_adr", adr_log[i], 32'h300);
    check("t3_rsum", bus.spi_in[47:16], 32'h1);
    check("t3_rdata", bus.spi_in[79:48], 32'h2);
    check("t3_beats", bus.spi_in[15:8], 2);

    // Timeout, then a fresh start clears the flag.
    ack_at = 0;
    issue(32'h400, 32'h0, 8'd0, 1'b0, 1'b0);
    wait_idle(nc, nb);
    check("t4_cyc_cycles", nc, 8);
    check("t4_timeout", bus.spi_in[4], 1);
    check("t4_beats", bus.spi_in[15:8], 0);
    ack_at = 1;
    issue(32'h404, 32'h0, 8'd0, 1'b1, 1'b0);
    check("t4_timeout_cleared", bus.spi_in[4], 0);
    wait_idle(nc, nb);

    // Start while CPU not held in reset is rejected.
    bus.spi_out[7:0] = 8'h04;
    tick();
    check("t5_rejected", bus.spi_in[5], 1);
    check("t5_busy", bus.spi_in[3], 0);
    tick();
    check("t5_cyc", bus.o_wb_cyc, 0);
    bus.spi_out[7:0] = 8'h01;
    tick();

    // Start edge mid-burst is rejected, burst completes.
    ack_at = 3;
    issue(32'h600, 32'h12345678, 8'd2, 1'b1, 1'b1);
    check("t5_rej_cleared", bus.spi_in[5], 0);
    tick();
    bus.spi_out[2] = 1'b1;
    tick();
    bus.spi_out[2] = 1'b0;
    wait_idle(nc, nb);
    check("t5_rej_busy", bus.spi_in[5], 1);
    check("t5_beats", bus.spi_in[15:8], 3);

    // Abort during beat 2 of an 8-beat burst.
    ack_at = 2;
    issue(32'h700, 32'h5555AAAA, 8'd7, 1'b1, 1'b1);
    for (int i = 0; i < 50 && bus.spi_in[15:8] != 8'd1; i++) tick();
    check("t5_abort_reach", bus.spi_in[15:8], 1);
    tick();
    bus.spi_out[5] = 1'b1;
    tick();
    check("t5_abort_busy", bus.spi_in[3], 0);
    check("t5_abort_beats", bus.spi_in[15:8], 1);
    check("t5_abort_cyc", bus.o_wb_cyc, 0);
    bus.spi_out[5] = 1'b0;
    tick();

    // Async reset in the middle of a read burst.
    ack_at = 2;
    rd_q.push_back(32'h11111111);
    rd_q.push_back(32'h22222222);
    issue(32'h800, 32'h0, 8'd3, 1'b0, 1'b1);
    for (int i = 0; i < 50 && !(bus.spi_in[15:8] == 8'd1 && bus.o_wb_cyc); i++) tick();
    check("t6_in_burst", bus.o_wb_cyc, 1);
    #1 spi_reset = 1'b0;
    #1;
    check("t6_cyc", bus.o_wb_cyc, 0);
    check("t6_spi_in", bus.spi_in, 80'h1);
    check("t6_adr", bus.o_wb_adr, 0);
    tick();
    spi_reset = 1'b1;
    rd_q.delete();
    tick();

    // Random commands, acks, aborts and occasional resets.
    rand_ack = 1;
    for (int k = 0; k < 4000; k++) begin
      ack_pct = (k < 2000) ? 35 : 10;
      c = bus.spi_out[7:0];
      if ($urandom_range(9) == 0) begin
        bus.spi_out[83:8] = {$urandom, $urandom, 4'($urandom), 8'($urandom_range(0, 6))};
        c[4:3] = 2'($urandom);
      end
      if ($urandom_range(3) == 0) c[2] = ~c[2];
      c[0] = ($urandom_range(9) != 0);
      c[1] = ($urandom_range(19) == 0);
      c[5] = ($urandom_range(39) == 0);
      c[7:6] = 2'($urandom);
      bus.spi_out[7:0] = c;
      spi_reset = ($urandom_range(599) != 0);
      tick();
    end
    spi_reset = 1'b1;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
